// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - mode constants, state encoding and next-bit function
// for the 4-bit feedback-shift sequence family.
package seq_pkg;

  localparam logic [1:0] MODE_RING = 2'd0;
  localparam logic [1:0] MODE_A    = 2'd1;
  localparam logic [1:0] MODE_B    = 2'd2;
  localparam logic [1:0] MODE_MAX  = 2'd3;

  localparam int NUM_MODES = 4;
  localparam int HIST_W    = 4;
  localparam int RUN_W     = 4;
  localparam int FILL_LEN  = 4;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  // h[0] is the newest bit, h[3] the oldest.
  function automatic logic seq_next(input logic [1:0] mode, input logic [HIST_W-1:0] h);
    logic nb;
    case (mode)
      MODE_RING: nb = ~(h[0] | h[1] | h[2]);
      MODE_A:    nb = ~h[3] | (~h[2] & ~h[1] &  h[0]);
      MODE_B:    nb = ~h[3] | ( h[2] & ~h[1] & ~h[0]);
      default:   nb = (h[0] ^ h[3]) | (h == 4'b0000);
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/seq_lock_checker_if.sv
// rtl/seq_lock_checker_if.sv - serial bit input and lock/error status bundle.
interface seq_lock_checker_if #(
  parameter int ERRW = 8
);

  logic            bit_in;
  logic            bit_valid;
  logic            locked;
  logic [1:0]      lock_mode;
  logic            err_pulse;
  logic [ERRW-1:0] err_count;

  modport master (
    output bit_in,
    output bit_valid,
    input  locked,
    input  lock_mode,
    input  err_pulse,
    input  err_count
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output locked,
    output lock_mode,
    output err_pulse,
    output err_count
  );

endinterface

// File: rtl/seq_predictor.sv
// rtl/seq_predictor.sv - next-bit prediction for all four modes from one history.
module seq_predictor
  import seq_pkg::*;
(
  input  logic [HIST_W-1:0]    hist_i,
  output logic [NUM_MODES-1:0] pred_o
);

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_mode
    assign pred_o[g] = seq_next(2'(g), hist_i);
  end

endmodule

// File: rtl/seq_lock_checker.sv
// rtl/seq_lock_checker.sv - identifies the sequence mode on a serial stream,
// locks to it and counts bit errors against a flywheel prediction.
module seq_lock_checker
  import seq_pkg::*;
#(
  parameter int LOCK_LEN = 8,
  parameter int LOSS_LEN = 3,
  parameter int ERRW     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_lock_checker_if.slave  bus
);

  state_e                state_q;
  logic [HIST_W-1:0]     hist_q;
  logic [2:0]            fill_q;
  logic [RUN_W-1:0]      run_q [NUM_MODES];
  logic [RUN_W-1:0]      miss_q;
  logic                  locked_q;
  logic [1:0]            lock_mode_q;
  logic                  err_pulse_q;
  logic [ERRW-1:0]       err_count_q;

  logic [NUM_MODES-1:0]  pred;
  logic                  fly_bit;
  logic [RUN_W-1:0]      run_d [NUM_MODES];
  logic [NUM_MODES-1:0]  hit;
  logic [1:0]            hit_mode;
  logic [ERRW-1:0]       err_count_d;

  seq_predictor u_pred (
    .hist_i (hist_q),
    .pred_o (pred)
  );

  assign fly_bit = pred[lock_mode_q];

  always_comb begin
    for (int m = 0; m < NUM_MODES; m++) begin
      run_d[m] = '0;
      if (bus.bit_in == pred[m]) begin
        run_d[m] = (run_q[m] == {RUN_W{1'b1}}) ? run_q[m] : run_q[m] + 1'b1;
      end
      hit[m] = (run_d[m] >= RUN_W'(LOCK_LEN));
    end
  end

  // Descending scan so the lowest matching mode is the one left standing.
  always_comb begin
    hit_mode = MODE_RING;
    for (int m = NUM_MODES - 1; m >= 0; m--) begin
      if (hit[m]) hit_mode = 2'(m);
    end
  end

  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      hist_q      <= '0;
      fill_q      <= '0;
      for (int m = 0; m < NUM_MODES; m++) run_q[m] <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      lock_mode_q <= MODE_RING;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.bit_valid) begin
        case (state_q)
          ST_FILL: begin
            hist_q <= {hist_q[HIST_W-2:0], bus.bit_in};
            fill_q <= fill_q + 3'd1;
            if (fill_q == 3'(FILL_LEN - 1)) begin
              state_q <= ST_HUNT;
              for (int m = 0; m < NUM_MODES; m++) run_q[m] <= '0;
            end
          end
          ST_HUNT: begin
            hist_q <= {hist_q[HIST_W-2:0], bus.bit_in};
            for (int m = 0; m < NUM_MODES; m++) run_q[m] <= run_d[m];
            if (|hit) begin
              state_q     <= ST_LOCK;
              lock_mode_q <= hit_mode;
              miss_q      <= '0;
              locked_q    <= 1'b1;
            end
          end
          ST_LOCK: begin
            // Flywheel: history advances on the prediction, never on the received bit.
            hist_q <= {hist_q[HIST_W-2:0], fly_bit};
            if (bus.bit_in != fly_bit) begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
              if (miss_q == RUN_W'(LOSS_LEN - 1)) begin
                state_q  <= ST_FILL;
                fill_q   <= '0;
                miss_q   <= '0;
                locked_q <= 1'b0;
              end else begin
                miss_q <= miss_q + 1'b1;
              end
            end else begin
              miss_q <= '0;
            end
          end
          default: begin
            state_q <= ST_FILL;
            fill_q  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.lock_mode = lock_mode_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_seq_lock_checker.sv
// tb/tb_seq_lock_checker.sv - directed bench for seq_lock_checker.
module tb_seq_lock_checker;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic m3pat [15];

  seq_lock_checker_if #(.ERRW(8)) bus ();
  seq_lock_checker_if #(.ERRW(4)) bus4 ();

  seq_lock_checker #(.LOCK_LEN(8), .LOSS_LEN(3), .ERRW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_lock_checker #(.LOCK_LEN(8), .LOSS_LEN(3), .ERRW(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic m0(input int k);
    return (k % 4) == 0;
  endfunction

  // Called at a negedge; returns at the next negedge with the edge's result visible.
  task automatic drive(input logic b, input logic v);
    bus.bit_in    = b;
    bus.bit_valid = v;
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  task automatic drive4(input logic b, input logic v);
    bus4.bit_in    = b;
    bus4.bit_valid = v;
    @(negedge clk);
    bus4.bit_valid = 1'b0;
  endtask

  initial begin
    m3pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst_n          = 1'b0;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus4.bit_in    = 1'b0;
    bus4.bit_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_locked",    32'(bus.locked),    32'd0);
    check("rst_lock_mode", 32'(bus.lock_mode), 32'd0);
    check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    rst_n = 1'b1;

    // Mode 0 lock after 12 bits
    for (int k = 0; k < 11; k++) drive(m0(k), 1'b1);
    check("m0_locked_11", 32'(bus.locked), 32'd0);
    drive(m0(11), 1'b1);
    check("m0_locked_12", 32'(bus.locked),    32'd1);
    check("m0_lock_mode", 32'(bus.lock_mode), 32'd0);
    check("m0_err_count", 32'(bus.err_count), 32'd0);

    // Single inverted bit while locked
    drive(m0(12), 1'b1);
    drive(~m0(13), 1'b1);
    check("flip_pulse",  32'(bus.err_pulse), 32'd1);
    check("flip_count",  32'(bus.err_count), 32'd1);
    check("flip_locked", 32'(bus.locked),    32'd1);
    drive(m0(14), 1'b1);
    check("flip_pulse_off", 32'(bus.err_pulse), 32'd0);
    for (int k = 15; k <= 32; k++) drive(m0(k), 1'b1);
    check("flip_count_after",  32'(bus.err_count), 32'd1);
    check("flip_locked_after", 32'(bus.locked),    32'd1);

    // Generator switched to mode 3: three errors, loss, relock on mode 3
    drive(m3pat[0], 1'b1);
    check("sw_pulse1",  32'(bus.err_pulse), 32'd1);
    check("sw_locked1", 32'(bus.locked),    32'd1);
    check("sw_count1",  32'(bus.err_count), 32'd2);
    drive(m3pat[1], 1'b1);
    check("sw_locked2", 32'(bus.locked),    32'd1);
    check("sw_count2",  32'(bus.err_count), 32'd3);
    drive(m3pat[2], 1'b1);
    check("sw_locked3", 32'(bus.locked),    32'd0);
    check("sw_count3",  32'(bus.err_count), 32'd4);
    check("sw_mode_kept", 32'(bus.lock_mode), 32'd0);
    for (int k = 3; k <= 13; k++) drive(m3pat[k], 1'b1);
    check("sw_relock_early", 32'(bus.locked), 32'd0);
    drive(m3pat[14], 1'b1);
    check("sw_relock",       32'(bus.locked),    32'd1);
    check("sw_relock_mode",  32'(bus.lock_mode), 32'd3);
    check("sw_relock_count", 32'(bus.err_count), 32'd4);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked",    32'(bus.locked),    32'd0);
    check("arst_lock_mode", 32'(bus.lock_mode), 32'd0);
    check("arst_err_pulse", 32'(bus.err_pulse), 32'd0);
    check("arst_err_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) drive(m0(k), 1'b1);
    check("arst_relock_11", 32'(bus.locked), 32'd0);
    drive(m0(11), 1'b1);
    check("arst_relock_12", 32'(bus.locked),    32'd1);
    check("arst_relock_md", 32'(bus.lock_mode), 32'd0);

    // Mode 3 with a valid bit every third cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(m3pat[k], 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
    end
    check("m3_locked_11", 32'(bus.locked),    32'd0);
    check("m3_mode_11",   32'(bus.lock_mode), 32'd0);
    drive(m3pat[11], 1'b1);
    check("m3_locked_12", 32'(bus.locked),    32'd1);
    check("m3_lock_mode", 32'(bus.lock_mode), 32'd3);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("m3_idle_locked", 32'(bus.locked),    32'd1);
    check("m3_idle_count",  32'(bus.err_count), 32'd0);
    drive(m3pat[12], 1'b1);
    check("m3_next_pulse",  32'(bus.err_pulse), 32'd0);
    check("m3_next_locked", 32'(bus.locked),    32'd1);

    // ERRW=4: alternate flipped bits saturate the counter without loss
    for (int k = 0; k < 12; k++) drive4(m0(k), 1'b1);
    check("sat_locked", 32'(bus4.locked), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive4(~m0(12 + 2 * i), 1'b1);
      drive4(m0(13 + 2 * i), 1'b1);
    end
    check("sat_count",  32'(bus4.err_count), 32'd15);
    check("sat_locked_after", 32'(bus4.locked),    32'd1);
    check("sat_mode",   32'(bus4.lock_mode), 32'd0);
    check("sat_pulse",  32'(bus4.err_pulse), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
